// File: rtl/freq_calc_if.sv
// Bus between freq_calc and its consumer: period count in, frequency result,
// valid strobe and busy flag out.
interface freq_calc_if;
    logic [31:0] period_in;
    logic [31:0] freq_out;
    logic        freq_vld;
    logic        busy;

    modport master (output period_in, input freq_out, freq_vld, busy);
    modport slave  (input period_in, output freq_out, freq_vld, busy);
endinterface

// File: rtl/freq_calc.sv
// Period-to-frequency converter: CLK_HZ / (period_in+1) via a restoring divider.
// Define FREQ_CALC_AVG_EN to average four periods before each division.
module freq_calc #(
    parameter int unsigned CLK_HZ  = 125_000_000,
    parameter int unsigned REFRESH = 12_500_000
) (
    input  logic        clk,
    input  logic        rstn,
    freq_calc_if.slave  bus
);

`ifdef FREQ_CALC_AVG_EN
    localparam int DVD_W = 34;
    localparam int DIV_W = 35;
`else
    localparam int DVD_W = 32;
    localparam int DIV_W = 33;
`endif
    localparam int          REM_W   = DIV_W + 1;
    localparam logic [5:0]  NBITS   = 6'(DVD_W);
    localparam logic [31:0] REF_MAX = 32'(REFRESH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      last_period_q, last_period_d;
    logic [31:0]      refresh_cnt_q, refresh_cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [DVD_W-1:0] dvd_q, dvd_d;
    logic [31:0]      quo_q, quo_d;
    logic [5:0]       bitcnt_q, bitcnt_d;
    logic [31:0]      freq_out_q, freq_out_d;
    logic             freq_vld_q, freq_vld_d;
    logic             busy_q, busy_d;
`ifdef FREQ_CALC_AVG_EN
    logic [34:0]      acc_q, acc_d;
    logic [1:0]       smp_q, smp_d;
    logic             skip_q, skip_d;
    logic [34:0]      acc_sum;
`endif

    logic             start;
    logic [32:0]      divisor_new;
    logic [REM_W:0]   step;

    // One restoring step: returns {quotient bit, next remainder}.
    function automatic logic [REM_W:0] div_step(input logic [REM_W-1:0] rem,
                                                input logic             nbit,
                                                input logic [DIV_W-1:0] dvs);
        logic [REM_W-1:0] sh;
        sh = (rem << 1) | REM_W'(nbit);
        if (sh >= {1'b0, dvs})
            return {1'b1, sh - {1'b0, dvs}};
        else
            return {1'b0, sh};
    endfunction

    assign start       = (bus.period_in != last_period_q) || (refresh_cnt_q >= REF_MAX);
    assign divisor_new = {1'b0, bus.period_in} + 33'd1;
    assign step        = div_step(rem_q, dvd_q[DVD_W-1], div_q);
`ifdef FREQ_CALC_AVG_EN
    assign acc_sum     = acc_q + {2'b00, divisor_new};
`endif

    always_comb begin
        state_d       = state_q;
        last_period_d = last_period_q;
        refresh_cnt_d = (refresh_cnt_q < REF_MAX) ? refresh_cnt_q + 32'd1 : refresh_cnt_q;
        div_d         = div_q;
        rem_d         = rem_q;
        dvd_d         = dvd_q;
        quo_d         = quo_q;
        bitcnt_d      = bitcnt_q;
        freq_out_d    = freq_out_q;
        freq_vld_d    = 1'b0;
        busy_d        = busy_q;
`ifdef FREQ_CALC_AVG_EN
        acc_d         = acc_q;
        smp_d         = smp_q;
        skip_d        = skip_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    last_period_d = bus.period_in;
                    refresh_cnt_d = 32'd0;
                    rem_d         = '0;
                    quo_d         = 32'd0;
                    bitcnt_d      = 6'd0;
                    busy_d        = 1'b1;
`ifdef FREQ_CALC_AVG_EN
                    if (smp_q == 2'd3) begin
                        div_d   = acc_sum;
                        dvd_d   = {32'(CLK_HZ), 2'b00};
                        acc_d   = '0;
                        smp_d   = 2'd0;
                        state_d = S_DIV;
                    end else begin
                        // Partial sample: pass through DONE without a result.
                        acc_d   = acc_sum;
                        smp_d   = smp_q + 2'd1;
                        skip_d  = 1'b1;
                        state_d = S_DONE;
                    end
`else
                    div_d   = divisor_new;
                    dvd_d   = 32'(CLK_HZ);
                    state_d = S_DIV;
`endif
                end
            end
            S_DIV: begin
                if (bitcnt_q == NBITS) begin
                    state_d = S_DONE;
                end else begin
                    rem_d    = step[REM_W-1:0];
                    quo_d    = (quo_q << 1) | 32'(step[REM_W]);
                    dvd_d    = dvd_q << 1;
                    bitcnt_d = bitcnt_q + 6'd1;
                end
            end
            S_DONE: begin
`ifdef FREQ_CALC_AVG_EN
                if (skip_q) begin
                    skip_d = 1'b0;
                end else begin
                    freq_out_d = quo_q;
                    freq_vld_d = 1'b1;
                end
`else
                freq_out_d = quo_q;
                freq_vld_d = 1'b1;
`endif
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            last_period_q <= 32'd0;
            refresh_cnt_q <= 32'd0;
            div_q         <= '0;
            rem_q         <= '0;
            dvd_q         <= '0;
            quo_q         <= 32'd0;
            bitcnt_q      <= 6'd0;
            freq_out_q    <= 32'd0;
            freq_vld_q    <= 1'b0;
            busy_q        <= 1'b0;
`ifdef FREQ_CALC_AVG_EN
            acc_q         <= '0;
            smp_q         <= 2'd0;
            skip_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            last_period_q <= last_period_d;
            refresh_cnt_q <= refresh_cnt_d;
            div_q         <= div_d;
            rem_q         <= rem_d;
            dvd_q         <= dvd_d;
            quo_q         <= quo_d;
            bitcnt_q      <= bitcnt_d;
            freq_out_q    <= freq_out_d;
            freq_vld_q    <= freq_vld_d;
            busy_q        <= busy_d;
`ifdef FREQ_CALC_AVG_EN
            acc_q         <= acc_d;
            smp_q         <= smp_d;
            skip_q        <= skip_d;
`endif
        end
    end

    assign bus.freq_out = freq_out_q;
    assign bus.freq_vld = freq_vld_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_freq_calc.sv
// Directed bench for freq_calc: latency, boundaries, refresh, mid-division
// period change and asynchronous reset (averaging sequence when enabled).
module tb_freq_calc;
    localparam int unsigned CLK_HZ  = 125_000_000;
    localparam int unsigned REFRESH = 1000;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   lat;
    int   bcnt;
    int   vcnt;

    freq_calc_if bus();

    freq_calc #(.CLK_HZ(CLK_HZ), .REFRESH(REFRESH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Edges from now until freq_vld is seen (-1 if never), counting busy cycles.
    task automatic run_to_vld(input int max, output int l, output int b);
        l = -1;
        b = 0;
        for (int n = 1; n <= max; n++) begin
            @(posedge clk);
            #1;
            if (bus.busy) b++;
            if (bus.freq_vld) begin
                l = n;
                break;
            end
        end
    endtask

    initial begin
        bus.period_in = 32'd0;
        rstn          = 1'b0;
        step(3);
        chk("rst_freq_out", bus.freq_out, 0);
        chk("rst_freq_vld", bus.freq_vld, 0);
        chk("rst_busy", bus.busy, 0);
        rstn = 1'b1;

`ifdef FREQ_CALC_AVG_EN
        vcnt = 0;
        bus.period_in = 32'd99;  step(3); vcnt += bus.freq_vld;
        bus.period_in = 32'd199; step(3); vcnt += bus.freq_vld;
        bus.period_in = 32'd299; step(3); vcnt += bus.freq_vld;
        chk("avg_no_partial_vld", vcnt, 0);
        bus.period_in = 32'd399;
        run_to_vld(60, lat, bcnt);
        chk("avg_latency", lat, 37);
        chk("avg_busy_cycles", bcnt, 36);
        chk("avg_freq_500k", bus.freq_out, 500_000);
        step(1);
        chk("avg_vld_pulse", bus.freq_vld, 0);
        bus.period_in = 32'd1; step(3);
        bus.period_in = 32'd2; step(3);
        bus.period_in = 32'd3; step(3);
        chk("avg_hold", bus.freq_out, 500_000);
        bus.period_in = 32'd4;
        run_to_vld(60, lat, bcnt);
        chk("avg2_latency", lat, 37);
        chk("avg2_freq", bus.freq_out, 35_714_285);
`else
        // Basic conversion and busy window
        bus.period_in = 32'd124;
        run_to_vld(60, lat, bcnt);
        chk("p124_latency", lat, 35);
        chk("p124_busy_cycles", bcnt, 34);
        chk("p124_freq", bus.freq_out, 1_000_000);

        // Boundaries, driven right at the strobe to probe minimum spacing
        bus.period_in = 32'd0;
        run_to_vld(60, lat, bcnt);
        chk("p0_spacing", lat, 35);
        chk("p0_freq", bus.freq_out, 125_000_000);
        step(1);
        chk("vld_single_pulse", bus.freq_vld, 0);
        step(5);
        chk("freq_hold", bus.freq_out, 125_000_000);
        bus.period_in = 32'hFFFF_FFFF;
        run_to_vld(60, lat, bcnt);
        chk("pmax_latency", lat, 35);
        chk("pmax_freq", bus.freq_out, 0);

        // Periodic refresh with an unchanged period
        bus.period_in = 32'd1249;
        run_to_vld(60, lat, bcnt);
        chk("p1249_freq", bus.freq_out, 100_000);
        run_to_vld(1100, lat, bcnt);
        chk("refresh1_spacing", lat, 1000);
        chk("refresh1_freq", bus.freq_out, 100_000);
        run_to_vld(1100, lat, bcnt);
        chk("refresh2_spacing", lat, 1000);
        chk("refresh2_freq", bus.freq_out, 100_000);

        // Period change 10 cycles into DIV
        bus.period_in = 32'd124;
        step(11);
        bus.period_in = 32'd249;
        run_to_vld(60, lat, bcnt);
        chk("midchg_first_lat", lat, 24);
        chk("midchg_first_freq", bus.freq_out, 1_000_000);
        run_to_vld(60, lat, bcnt);
        chk("midchg_second_lat", lat, 35);
        chk("midchg_second_freq", bus.freq_out, 500_000);

        // Asynchronous reset 20 cycles into DIV
        bus.period_in = 32'd124;
        step(21);
        rstn = 1'b0;
        #1;
        chk("async_rst_freq_out", bus.freq_out, 0);
        chk("async_rst_freq_vld", bus.freq_vld, 0);
        chk("async_rst_busy", bus.busy, 0);
        step(2);
        bus.period_in = 32'd0;
        rstn = 1'b1;
        run_to_vld(60, lat, bcnt);
        chk("post_rst_no_vld", lat, -1);
        chk("post_rst_idle", bcnt, 0);
        bus.period_in = 32'd124;
        run_to_vld(60, lat, bcnt);
        chk("post_rst_lat", lat, 35);
        chk("post_rst_freq", bus.freq_out, 1_000_000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
